// File: rtl/ball_pkg.sv
// ----------------------------------------------------------------------------
// ball_pkg
// Shared constants, types and arithmetic helpers for the ball motion block.
//   SPEED_W / COORD_W : width of speeds and of pixel coordinates
//   state_t           : motion state (HOLD frozen, MOVE integrating)
//   FLAG_*            : bit positions of the latched collision vector
//   sat_add()         : signed add clamped to [-limit, +limit]
//   reflect()         : force a speed to a given direction; when
//                       BALL_BOUNCE_DAMP_EN is defined the magnitude is also
//                       reduced by a loss, floored at zero
// ----------------------------------------------------------------------------
package ball_pkg;

    localparam int SPEED_W = 11;
    localparam int COORD_W = 11;

    localparam int FLAG_TOP     = 0;
    localparam int FLAG_LEFT    = 1;
    localparam int FLAG_RIGHT   = 2;
    localparam int FLAG_FLIPPER = 3;

    typedef enum logic [0:0] {
        HOLD = 1'b0,
        MOVE = 1'b1
    } state_t;

    typedef logic signed [SPEED_W-1:0] speed_t;

    // Add in one extra bit so the sum cannot wrap before it is clamped.
    function automatic speed_t sat_add(input speed_t speed,
                                       input speed_t delta,
                                       input speed_t limit);
        logic signed [SPEED_W:0] s_ext;
        logic signed [SPEED_W:0] d_ext;
        logic signed [SPEED_W:0] l_ext;
        logic signed [SPEED_W:0] sum;
        s_ext = {speed[SPEED_W-1], speed};
        d_ext = {delta[SPEED_W-1], delta};
        l_ext = {limit[SPEED_W-1], limit};
        sum   = s_ext + d_ext;
        if (sum > l_ext) begin
            return limit;
        end else if (sum < -l_ext) begin
            return -limit;
        end else begin
            return sum[SPEED_W-1:0];
        end
    endfunction

    // Reflection keeps only the magnitude; the caller picks the new direction.
    function automatic speed_t reflect(input speed_t speed,
                                       input logic   to_pos,
                                       input speed_t loss);
        speed_t mag;
        mag = speed[SPEED_W-1] ? -speed : speed;
`ifdef BALL_BOUNCE_DAMP_EN
        mag = (mag > loss) ? (mag - loss) : speed_t'(11'sd0);
`else
        mag = mag + (loss & speed_t'(11'sd0));
`endif
        return to_pos ? mag : -mag;
    endfunction

endpackage

// File: rtl/ball_motion_if.sv
// ----------------------------------------------------------------------------
// ball_motion_if
// Bundles the game-controller side of the ball motion block.
//   master : game controller / video side (drives frame, control and
//            collision flags, observes the ball position)
//   slave  : ball_motion itself
// Signals:
//   startOfFrame, pause, reset_level            control from game controller
//   collisionSmileyBorder{Top,Left,Right}       per-pixel border collisions
//   collisionSmileyFlipper                      per-pixel flipper collision
//   topLeftX, topLeftY (11-bit signed)          ball top-left pixel
//   moving                                      1 while in MOVE state
// ----------------------------------------------------------------------------
interface ball_motion_if;
    import ball_pkg::*;

    logic                       startOfFrame;
    logic                       pause;
    logic                       reset_level;
    logic                       collisionSmileyBorderTop;
    logic                       collisionSmileyBorderLeft;
    logic                       collisionSmileyBorderRight;
    logic                       collisionSmileyFlipper;
    logic signed [COORD_W-1:0]  topLeftX;
    logic signed [COORD_W-1:0]  topLeftY;
    logic                       moving;

    modport master (
        output startOfFrame, pause, reset_level,
        output collisionSmileyBorderTop, collisionSmileyBorderLeft,
        output collisionSmileyBorderRight, collisionSmileyFlipper,
        input  topLeftX, topLeftY, moving
    );

    modport slave (
        input  startOfFrame, pause, reset_level,
        input  collisionSmileyBorderTop, collisionSmileyBorderLeft,
        input  collisionSmileyBorderRight, collisionSmileyFlipper,
        output topLeftX, topLeftY, moving
    );

endinterface

// File: rtl/ball_motion_collision_latch.sv
// ----------------------------------------------------------------------------
// collision_latch
// Four sticky collision flags gathered during scan-out and handed to the
// frame update at startOfFrame.
//   clk, reset  : clock, synchronous active-high reset
//   i_clear     : level restart, discards everything latched so far
//   i_sof       : start-of-frame pulse (the cycle the flags are consumed)
//   i_flags     : per-pixel collision inputs (see FLAG_* in ball_pkg)
//   o_flags     : latched flags for the frame update
// ----------------------------------------------------------------------------
module collision_latch
    import ball_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_sof,
    input  logic [3:0] i_flags,
    output logic [3:0] o_flags
);

    logic [3:0] r_flags;

    // Sticky accumulation; on startOfFrame the old set is consumed and only
    // flags arriving on that very cycle carry over into the next frame.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_flags <= 4'b0000;
        end else if (i_sof) begin
            r_flags <= i_flags;
        end else begin
            r_flags <= r_flags | i_flags;
        end
    end

    assign o_flags = r_flags;

endmodule

// File: rtl/ball_motion.sv
// ----------------------------------------------------------------------------
// ball_motion
// Integrates the smiley ball's velocity and position once per video frame,
// applying border bounces, flipper kicks and gravity.
// Ports:
//   clk   : system/pixel clock
//   reset : synchronous, active-high
//   bus   : ball_motion_if.slave (frame/control/collision inputs,
//           topLeftX/topLeftY/moving outputs)
// Optional build macro: BALL_BOUNCE_DAMP_EN -- border bounces lose
//   BOUNCE_LOSS of speed magnitude (floored at zero); flipper kicks are
//   never damped.
// Position is fixed point with FRAC_BITS fractional bits; the pixel outputs
// are the integer part of the registered position.
// The startOfFrame that releases HOLD also performs that frame's update, so
// motion starts on the same frame the pause is lifted.
// ----------------------------------------------------------------------------
module ball_motion
    import ball_pkg::*;
#(
    parameter int INITIAL_X       = 280,
    parameter int INITIAL_Y       = 185,
    parameter int INITIAL_X_SPEED = 40,
    parameter int INITIAL_Y_SPEED = 20,
    parameter int GRAVITY         = 1,
    parameter int MAX_Y_SPEED     = 230,
    parameter int FLIPPER_KICK    = 200,
    parameter int FRAC_BITS       = 6,
    parameter int BOUNCE_LOSS     = 4
)
(
    input  logic          clk,
    input  logic          reset,
    ball_motion_if.slave  bus
);

    localparam int POS_W = COORD_W + FRAC_BITS;

    localparam logic signed [POS_W-1:0] INIT_POS_X = POS_W'(INITIAL_X << FRAC_BITS);
    localparam logic signed [POS_W-1:0] INIT_POS_Y = POS_W'(INITIAL_Y << FRAC_BITS);
    localparam speed_t INIT_SPEED_X = speed_t'(INITIAL_X_SPEED);
    localparam speed_t INIT_SPEED_Y = speed_t'(INITIAL_Y_SPEED);
    localparam speed_t GRAV         = speed_t'(GRAVITY);
    localparam speed_t MAX_VY       = speed_t'(MAX_Y_SPEED);
    localparam speed_t KICK_UP      = speed_t'(-FLIPPER_KICK);
    localparam speed_t LOSS         = speed_t'(BOUNCE_LOSS);

    state_t                  r_state;
    state_t                  w_state_next;
    logic signed [POS_W-1:0] r_pos_x;
    logic signed [POS_W-1:0] r_pos_y;
    speed_t                  r_speed_x;
    speed_t                  r_speed_y;

    logic [3:0]              w_flags;
    logic                    w_update;
    speed_t                  w_speed_x_next;
    speed_t                  w_speed_y_bounce;
    speed_t                  w_speed_y_next;
    logic signed [POS_W-1:0] w_pos_x_next;
    logic signed [POS_W-1:0] w_pos_y_next;

    collision_latch u_collision_latch (
        .clk     (clk),
        .reset   (reset),
        .i_clear (bus.reset_level),
        .i_sof   (bus.startOfFrame),
        .i_flags ({bus.collisionSmileyFlipper,
                   bus.collisionSmileyBorderRight,
                   bus.collisionSmileyBorderLeft,
                   bus.collisionSmileyBorderTop}),
        .o_flags (w_flags)
    );

    // A frame is integrated whenever it starts unpaused, whatever the state.
    assign w_update = bus.startOfFrame & ~bus.pause;

    // Next-state logic: transitions are only evaluated at frame start.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HOLD: begin
                if (bus.startOfFrame && !bus.pause) begin
                    w_state_next = MOVE;
                end else begin
                    w_state_next = HOLD;
                end
            end
            MOVE: begin
                if (bus.startOfFrame && bus.pause) begin
                    w_state_next = HOLD;
                end else begin
                    w_state_next = MOVE;
                end
            end
            default: begin
                w_state_next = HOLD;
            end
        endcase
    end

    // Frame arithmetic: bounces first, then gravity, then position.
    always_comb begin
        w_speed_x_next   = r_speed_x;
        w_speed_y_bounce = r_speed_y;

        // Hitting both side walls at once just flips the current direction.
        if (w_flags[FLAG_LEFT] && w_flags[FLAG_RIGHT]) begin
            w_speed_x_next = reflect(r_speed_x, r_speed_x[SPEED_W-1], LOSS);
        end else if (w_flags[FLAG_LEFT]) begin
            w_speed_x_next = reflect(r_speed_x, 1'b1, LOSS);
        end else if (w_flags[FLAG_RIGHT]) begin
            w_speed_x_next = reflect(r_speed_x, 1'b0, LOSS);
        end else begin
            w_speed_x_next = r_speed_x;
        end

        // The flipper kick wins over a simultaneous top-border bounce.
        if (w_flags[FLAG_FLIPPER]) begin
            w_speed_y_bounce = KICK_UP;
        end else if (w_flags[FLAG_TOP]) begin
            w_speed_y_bounce = reflect(r_speed_y, 1'b1, LOSS);
        end else begin
            w_speed_y_bounce = r_speed_y;
        end

        w_speed_y_next = sat_add(w_speed_y_bounce, GRAV, MAX_VY);

        w_pos_x_next = r_pos_x + $signed({{(POS_W-SPEED_W){w_speed_x_next[SPEED_W-1]}},
                                          w_speed_x_next});
        w_pos_y_next = r_pos_y + $signed({{(POS_W-SPEED_W){w_speed_y_next[SPEED_W-1]}},
                                          w_speed_y_next});
    end

    // State, position and speed registers; reset_level restarts like reset.
    always_ff @(posedge clk) begin
        if (reset || bus.reset_level) begin
            r_state   <= HOLD;
            r_pos_x   <= INIT_POS_X;
            r_pos_y   <= INIT_POS_Y;
            r_speed_x <= INIT_SPEED_X;
            r_speed_y <= INIT_SPEED_Y;
        end else begin
            r_state <= w_state_next;
            if (w_update) begin
                r_pos_x   <= w_pos_x_next;
                r_pos_y   <= w_pos_y_next;
                r_speed_x <= w_speed_x_next;
                r_speed_y <= w_speed_y_next;
            end else begin
                r_pos_x   <= r_pos_x;
                r_pos_y   <= r_pos_y;
                r_speed_x <= r_speed_x;
                r_speed_y <= r_speed_y;
            end
        end
    end

    // Integer part of a signed fixed-point value is its upper bits.
    assign bus.topLeftX = r_pos_x[POS_W-1:FRAC_BITS];
    assign bus.topLeftY = r_pos_y[POS_W-1:FRAC_BITS];
    assign bus.moving   = (r_state == MOVE);

endmodule
